// File: rtl/s3g_uart_rx.sv
// s3g_uart_rx: 8N1 serial receiver, 16x oversampling with 3-sample majority vote.
// Ports: clk, rst (sync high), rx (async line), rx_data/rx_done (good byte), frame_error, busy.
module s3g_uart_rx #(
  parameter int DIV = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_error,
  output logic       busy
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic          rxs1;
  logic          rxs2;
  logic [CW-1:0] divcnt;
  logic [3:0]    s;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          v7;
  logic          v8;
  logic          tick;
  logic          vote;

  assign tick = (divcnt == DIV_M1);
  assign vote = (v7 & v8) | (v7 & rxs2) | (v8 & rxs2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rxs1        <= 1'b1;
      rxs2        <= 1'b1;
      divcnt      <= '0;
      s           <= 4'd0;
      bitcnt      <= 3'd0;
      shreg       <= 8'h00;
      v7          <= 1'b0;
      v8          <= 1'b0;
      rx_data     <= 8'h00;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rxs1        <= rx;
      rxs2        <= rxs1;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;

      divcnt <= tick ? '0 : divcnt + 1'b1;
      if (tick) begin
        s <= s + 4'd1;
      end
      if (tick && s == 4'd7) begin
        v7 <= rxs2;
      end
      if (tick && s == 4'd8) begin
        v8 <= rxs2;
      end

      unique case (state)
        IDLE: begin
          if (!rxs2) begin
            state  <= START;
            busy   <= 1'b1;
            divcnt <= '0;
            s      <= 4'd0;
          end
        end
        START: begin
          if (tick && s == 4'd9 && vote) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tick && s == 4'd15) begin
            state  <= DATA;
            bitcnt <= 3'd0;
          end
        end
        DATA: begin
          if (tick && s == 4'd9) begin
            shreg <= {vote, shreg[7:1]};
          end
          if (tick && s == 4'd15) begin
            if (bitcnt == 3'd7) begin
              state <= STOP;
            end else begin
              bitcnt <= bitcnt + 3'd1;
            end
          end
        end
        STOP: begin
          // decided mid-bit so a back-to-back start edge is not missed
          if (tick && s == 4'd9) begin
            if (vote) begin
              rx_data <= shreg;
              rx_done <= 1'b1;
              state   <= IDLE;
              busy    <= 1'b0;
            end else begin
              frame_error <= 1'b1;
              state       <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (rxs2) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s3g_uart_rx.sv
// tb_s3g_uart_rx: random and directed frames for s3g_uart_rx, checked every
// cycle against an event-time model of the expected receiver outputs.
module tb_s3g_uart_rx;

  localparam int DIV = 4;
  localparam int BIT = 16 * DIV;
  localparam int LAT = 154 * DIV + 2;
  localparam int BIG = 32'h7fffffff;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_error;
  logic       busy;

  s3g_uart_rx #(.DIV(DIV)) dut (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .frame_error(frame_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lo;
    int hi;
  } span_t;

  typedef struct {
    int         e;
    logic [7:0] d;
  } ev_t;

  span_t      busy_q[$];
  logic [7:0] done_map[int];
  bit         fe_map[int];
  bit         rst_map[int];
  ev_t        seen_done[$];
  int         seen_fe[$];
  int         edge_n = 0;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_data = 8'h00;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at edge %0d: got %0h expected %0h",
                 name, edge_n, act, exp);
    end
  endtask

  function automatic int find_done(input int e);
    foreach (seen_done[i])
      if (seen_done[i].e == e) return i;
    return -1;
  endfunction

  function automatic bit has_fe(input int e);
    foreach (seen_fe[i])
      if (seen_fe[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  // per-cycle compare against the model's event times
  initial begin
    bit exp_busy;
    forever begin
      @(posedge clk);
      #1;
      while (busy_q.size() > 0 && edge_n >= busy_q[0].hi)
        busy_q.delete(0);
      if (rst_map.exists(edge_n)) model_data = 8'h00;
      if (done_map.exists(edge_n)) model_data = done_map[edge_n];
      exp_busy = busy_q.size() > 0 && edge_n >= busy_q[0].lo;
      chk("rx_done", {31'd0, rx_done}, {31'd0, done_map.exists(edge_n) != 0});
      chk("frame_error", {31'd0, frame_error}, {31'd0, fe_map.exists(edge_n) != 0});
      chk("rx_data", {24'd0, rx_data}, {24'd0, model_data});
      chk("busy", {31'd0, busy}, {31'd0, exp_busy});
      if (rx_done === 1'b1) seen_done.push_back('{edge_n, rx_data});
      if (frame_error === 1'b1) seen_fe.push_back(edge_n);
    end
  end

  function automatic logic line_bit(input logic [7:0] d, input bit stop_ok,
                                    input int o);
    int b;
    b = o / BIT;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    return stop_ok;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      rx = 1'b1;
      @(negedge clk);
    end
  endtask

  // One frame; t0 is the edge that captures the start bit.
  // gk >= 0 inverts the line for one tick window around sample gk.
  task automatic send(input logic [7:0] d, input bit stop_ok, input int brk,
                      input int gk, output int t0);
    int n;
    int w;
    bit g;
    t0 = edge_n + 1;
    n = stop_ok ? 10 * BIT : 9 * BIT + brk;
    if (stop_ok) begin
      done_map[t0+LAT] = d;
      busy_q.push_back('{t0 + 2, t0 + LAT});
    end else begin
      fe_map[t0+LAT] = 1'b1;
      busy_q.push_back('{t0 + 2, t0 + n + 2});
    end
    w = (gk + 1) * DIV;
    for (int o = 0; o < n; o++) begin
      g = (gk >= 0) && (o >= w - 1) && (o <= w + DIV - 2);
      rx = line_bit(d, stop_ok, o) ^ g;
      @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic false_start(input int lo_n);
    int t0;
    t0 = edge_n + 1;
    busy_q.push_back('{t0 + 2, t0 + 2 + 10 * DIV});
    repeat (lo_n) begin
      rx = 1'b0;
      @(negedge clk);
    end
    rx = 1'b1;
  endtask

  initial begin
    int ta, tb0, tb1, tb2, tc, te, tf, tg, th, tr, tmp;
    int i1, gap, gk, brk, r, t0;
    bit ok;
    logic [7:0] d;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_data", {24'd0, rx_data}, 32'd0);
    chk("reset_done", {31'd0, rx_done}, 32'd0);
    idle(20);

    send(8'hD5, 1'b1, 0, -1, ta);
    idle(50);

    send(8'hD5, 1'b1, 0, -1, tb0);
    send(8'h03, 1'b1, 0, -1, tb1);
    send(8'h01, 1'b1, 0, -1, tb2);
    idle(30);

    false_start(3 * DIV);
    idle(2 * BIT);
    send(8'hCC, 1'b1, 0, -1, tc);
    idle(20);

    send(8'h55, 1'b0, 20 * BIT, -1, te);
    idle(10);
    send(8'h78, 1'b1, 0, -1, tf);
    idle(20);

    send(8'h0F, 1'b1, 0, 16 * 4 + 8, tg);
    idle(20);

    // partial frame (start + bits 0..4), then a one-cycle reset
    t0 = edge_n + 1;
    busy_q.push_back('{t0 + 2, BIG});
    for (int o = 0; o < 6 * BIT; o++) begin
      rx = line_bit(8'hA6, 1'b1, o);
      @(negedge clk);
    end
    rx  = 1'b1;
    rst = 1'b1;
    r = edge_n + 1;
    busy_q.delete(busy_q.size() - 1);
    busy_q.push_back('{t0 + 2, r});
    rst_map[r] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_data", {24'd0, rx_data}, 32'd0);
    idle(40);
    send(8'hF3, 1'b1, 0, -1, tr);
    idle(20);

    ok = 1'b1;
    for (int n = 0; n < 40; n++) begin
      d   = 8'($urandom_range(0, 255));
      gk  = ($urandom_range(0, 1) == 1) ?
            16 * int'($urandom_range(0, 8)) + int'($urandom_range(7, 9)) : -1;
      brk = $urandom_range(BIT, 10 * BIT);
      gap = $urandom_range(1, 150);
      if (ok && $urandom_range(0, 3) == 0) gap = 0;
      ok  = ($urandom_range(0, 99) < 85);
      idle(gap);
      send(d, ok, brk, gk, tmp);
    end
    idle(40);

    i1 = find_done(ta + 618);
    chk("t1_done_edge", {31'd0, i1 >= 0}, 32'd1);
    if (i1 >= 0) chk("t1_data", {24'd0, seen_done[i1].d}, 32'hD5);

    i1 = find_done(tb0 + 618);
    chk("b2b_first", {31'd0, i1 >= 0 && i1 + 2 < seen_done.size()}, 32'd1);
    if (i1 >= 0 && i1 + 2 < seen_done.size()) begin
      chk("b2b_gap1", seen_done[i1+1].e - seen_done[i1].e, 32'd640);
      chk("b2b_gap2", seen_done[i1+2].e - seen_done[i1+1].e, 32'd640);
      chk("b2b_d0", {24'd0, seen_done[i1].d}, 32'hD5);
      chk("b2b_d1", {24'd0, seen_done[i1+1].d}, 32'h03);
      chk("b2b_d2", {24'd0, seen_done[i1+2].d}, 32'h01);
    end

    i1 = find_done(tc + 618);
    chk("after_false_start", {31'd0, i1 >= 0}, 32'd1);
    if (i1 >= 0) chk("cc_data", {24'd0, seen_done[i1].d}, 32'hCC);

    chk("fe_edge", {31'd0, has_fe(te + 618)}, 32'd1);
    i1 = find_done(tf + 618);
    if (i1 >= 0) chk("after_fe_data", {24'd0, seen_done[i1].d}, 32'h78);
    else chk("after_fe_done", 32'd0, 32'd1);

    i1 = find_done(tg + 618);
    if (i1 >= 0) chk("glitch_data", {24'd0, seen_done[i1].d}, 32'h0F);
    else chk("glitch_done", 32'd0, 32'd1);

    i1 = find_done(tr + 618);
    if (i1 >= 0) chk("post_rst_data", {24'd0, seen_done[i1].d}, 32'hF3);
    else chk("post_rst_done", 32'd0, 32'd1);

    chk("done_count", seen_done.size(), done_map.size());
    chk("fe_count", seen_fe.size(), fe_map.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
